// File: rtl/muldiv_sequencer_pkg.sv
// Shared definitions for the multiply/divide sequencer: func codes, FSM
// state encoding and small decode helpers.
package muldiv_sequencer_pkg;

  localparam int unsigned MD_WIDTH = 32;

  localparam logic [5:0] FUNC_MULT  = 6'h18;
  localparam logic [5:0] FUNC_MULTU = 6'h19;
  localparam logic [5:0] FUNC_DIV   = 6'h1A;
  localparam logic [5:0] FUNC_DIVU  = 6'h1B;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_RUN  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } md_state_e;

  // True for any of the four multi-cycle ops.
  function automatic logic is_muldiv(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_MULTU) ||
           (func == FUNC_DIV)  || (func == FUNC_DIVU);
  endfunction

  function automatic logic is_div_func(input logic [5:0] func);
    return (func == FUNC_DIV) || (func == FUNC_DIVU);
  endfunction

  function automatic logic is_signed_func(input logic [5:0] func);
    return (func == FUNC_MULT) || (func == FUNC_DIV);
  endfunction

endpackage

// File: rtl/muldiv_sequencer_md_step_core.sv
// Iterative radix-2 datapath: 2*WIDTH accumulator plus the multiplicand /
// divisor register; one shift-add or restoring shift-subtract per step.
// Ports:
//   clock, reset  clock and synchronous active-high reset
//   load          load acc = {0, load_a}, operand = load_b
//   step          perform one iteration
//   is_div        selects divide step (1) or multiply step (0)
//   load_a        multiplier / dividend magnitude
//   load_b        multiplicand / divisor magnitude
//   acc           accumulator: {HI-part, LO-part}
module muldiv_sequencer_md_step_core
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               step,
  input  logic               is_div,
  input  logic [WIDTH-1:0]   load_a,
  input  logic [WIDTH-1:0]   load_b,
  output logic [2*WIDTH-1:0] acc
);

  logic [WIDTH-1:0]   operand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_rem;
  logic [WIDTH:0]     div_diff;

  // Next accumulator value for a single iteration.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} +
               (acc_q[0] ? {1'b0, operand_q} : (WIDTH+1)'(0));
    // Partial remainder after the left shift keeps its carried-out bit.
    div_rem  = acc_q[2*WIDTH-1:WIDTH-1];
    div_diff = div_rem - {1'b0, operand_q};
    if (is_div) begin
      if (!div_diff[WIDTH]) begin
        acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_step = {div_rem[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Accumulator and operand registers.
  always_ff @(posedge clock) begin
    if (reset) begin
      acc_q     <= '0;
      operand_q <= '0;
    end else if (load) begin
      acc_q     <= {WIDTH'(0), load_a};
      operand_q <= load_b;
    end else if (step) begin
      acc_q     <= acc_step;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle MULT/MULTU/DIV/DIVU controller with HI/LO ownership. Holds the
// pipeline while HI/LO access or a new op would observe stale results.
// Optional feature macro: MD_EARLY_DONE_EN -- a multiply with a zero operand
// or any divide by zero skips RUN (done two cycles after the start edge).
// Ports:
//   clock, reset         clock and synchronous active-high reset
//   i_start, i_func_6    issuing SPECIAL op and its func field
//   i_rs_32, i_rt_32     operands (i_rs_32 also carries MTHI/MTLO data)
//   i_rd_hi, i_rd_lo     MFHI / MFLO issuing
//   i_wr_hi, i_wr_lo     MTHI / MTLO issuing
//   o_hi_32, o_lo_32     HI / LO registers
//   o_busy               state is not IDLE
//   o_done               one-cycle pulse, new HI/LO visible
//   o_stall              combinational pipeline hold request
module muldiv_sequencer
  import muldiv_sequencer_pkg::*;
#(
  parameter int unsigned WIDTH = MD_WIDTH
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_start,
  input  logic [5:0]       i_func_6,
  input  logic [WIDTH-1:0] i_rs_32,
  input  logic [WIDTH-1:0] i_rt_32,
  input  logic             i_rd_hi,
  input  logic             i_rd_lo,
  input  logic             i_wr_hi,
  input  logic             i_wr_lo,
  output logic [WIDTH-1:0] o_hi_32,
  output logic [WIDTH-1:0] o_lo_32,
  output logic             o_busy,
  output logic             o_done,
  output logic             o_stall
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam int unsigned ACC_W = 2 * WIDTH;

  md_state_e        state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] rs_q;
  logic [WIDTH-1:0] rt_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             op_div_q;
  logic             op_signed_q;
  logic             busy_q;
  logic             done_q;

  logic             start_ok;
  logic             rs_neg;
  logic             rt_neg;
  logic             res_neg;
  logic             rs_zero;
  logic             rt_zero;
  logic [WIDTH-1:0] abs_rs;
  logic [WIDTH-1:0] abs_rt;
  logic [WIDTH-1:0] quot_fix;
  logic [WIDTH-1:0] rem_fix;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] prod_fix;
  logic             core_load;
  logic             core_step;

  // Sign handling is derived from the operands latched at acceptance.
  always_comb begin
    start_ok  = i_start && is_muldiv(i_func_6) &&
                ((state == ST_IDLE) || (state == ST_DONE));
    rs_neg    = op_signed_q & rs_q[WIDTH-1];
    rt_neg    = op_signed_q & rt_q[WIDTH-1];
    res_neg   = rs_neg ^ rt_neg;
    rs_zero   = (rs_q == '0);
    rt_zero   = (rt_q == '0);
    abs_rs    = rs_neg ? -rs_q : rs_q;
    abs_rt    = rt_neg ? -rt_q : rt_q;
    prod_fix  = res_neg ? -acc : acc;
    quot_fix  = res_neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    // Remainder follows the dividend's sign.
    rem_fix   = rs_neg ? -acc[ACC_W-1:WIDTH] : acc[ACC_W-1:WIDTH];
    core_load = (state == ST_PREP);
    core_step = (state == ST_RUN);
  end

  muldiv_sequencer_md_step_core #(
    .WIDTH (WIDTH)
  ) u_md_step_core (
    .clock  (clock),
    .reset  (reset),
    .load   (core_load),
    .step   (core_step),
    .is_div (op_div_q),
    .load_a (abs_rs),
    .load_b (abs_rt),
    .acc    (acc)
  );

  // Sequencer FSM, counter and HI/LO ownership.
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      hi_q        <= '0;
      lo_q        <= '0;
      op_div_q    <= 1'b0;
      op_signed_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        ST_IDLE, ST_DONE: begin
          if (start_ok) begin
            // A start wins over a simultaneous MTHI/MTLO.
            rs_q        <= i_rs_32;
            rt_q        <= i_rt_32;
            op_div_q    <= is_div_func(i_func_6);
            op_signed_q <= is_signed_func(i_func_6);
            busy_q      <= 1'b1;
            state       <= ST_PREP;
          end else begin
            if (i_wr_hi) hi_q <= i_rs_32;
            if (i_wr_lo) lo_q <= i_rs_32;
            busy_q <= 1'b0;
            state  <= ST_IDLE;
          end
        end
        ST_PREP: begin
          cnt <= CNT_W'(WIDTH - 1);
`ifdef MD_EARLY_DONE_EN
          if (op_div_q ? rt_zero : (rs_zero || rt_zero)) begin
            state <= ST_FIX;
          end else begin
            state <= ST_RUN;
          end
`else
          state <= ST_RUN;
`endif
        end
        ST_RUN: begin
          if (cnt == '0) begin
            state <= ST_FIX;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        ST_FIX: begin
          if (op_div_q) begin
            if (rt_zero) begin
              hi_q <= rs_q;
              lo_q <= '1;
            end else begin
              hi_q <= rem_fix;
              lo_q <= quot_fix;
            end
          end else if (rs_zero || rt_zero) begin
            // Accumulator is not a product if RUN was skipped.
            hi_q <= '0;
            lo_q <= '0;
          end else begin
            hi_q <= prod_fix[ACC_W-1:WIDTH];
            lo_q <= prod_fix[WIDTH-1:0];
          end
          done_q <= 1'b1;
          state  <= ST_DONE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_stall = (i_start | i_rd_hi | i_rd_lo | i_wr_hi | i_wr_lo) &
                   ((state == ST_PREP) || (state == ST_RUN) || (state == ST_FIX));
  assign o_hi_32 = hi_q;
  assign o_lo_32 = lo_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: table of directed ops, random ops checked
// against a language-arithmetic model, and hand-written corner sequences.
module tb_muldiv_sequencer;
  import muldiv_sequencer_pkg::*;

  localparam int unsigned W        = 32;
  localparam int          FULL_LAT = W + 2;

  logic          clock;
  logic          reset;
  logic          i_start;
  logic [5:0]    i_func_6;
  logic [W-1:0]  i_rs_32;
  logic [W-1:0]  i_rt_32;
  logic          i_rd_hi;
  logic          i_rd_lo;
  logic          i_wr_hi;
  logic          i_wr_lo;
  logic [W-1:0]  o_hi_32;
  logic [W-1:0]  o_lo_32;
  logic          o_busy;
  logic          o_done;
  logic          o_stall;

  int            checks;
  int            errors;
  logic [63:0]   sb_q[$];

  typedef struct {
    logic [5:0]  func;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[14];

  muldiv_sequencer #(.WIDTH(W)) dut (
    .clock    (clock),
    .reset    (reset),
    .i_start  (i_start),
    .i_func_6 (i_func_6),
    .i_rs_32  (i_rs_32),
    .i_rt_32  (i_rt_32),
    .i_rd_hi  (i_rd_hi),
    .i_rd_lo  (i_rd_lo),
    .i_wr_hi  (i_wr_hi),
    .i_wr_lo  (i_wr_lo),
    .o_hi_32  (o_hi_32),
    .o_lo_32  (o_lo_32),
    .o_busy   (o_busy),
    .o_done   (o_done),
    .o_stall  (o_stall)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Reference {HI,LO} from plain language arithmetic.
  function automatic logic [63:0] model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa;
    longint sb;
    longint q;
    longint r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    p  = '0;
    if (f == FUNC_MULT) begin
      p = 64'(sa * sb);
    end else if (f == FUNC_MULTU) begin
      p = {32'h0, a} * {32'h0, b};
    end else if (b == 32'h0) begin
      p = {a, 32'hFFFFFFFF};
    end else if (f == FUNC_DIV) begin
      q = sa / sb;
      r = sa % sb;
      p = {r[31:0], q[31:0]};
    end else begin
      p = {a % b, a / b};
    end
    return p;
  endfunction

  function automatic int exp_lat(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
`ifdef MD_EARLY_DONE_EN
    if ((f == FUNC_MULT || f == FUNC_MULTU) && (a == 32'h0 || b == 32'h0)) return 2;
    if ((f == FUNC_DIV || f == FUNC_DIVU) && b == 32'h0) return 2;
`endif
    return FULL_LAT;
  endfunction

  // Scoreboard: every o_done pops one expected {HI,LO}.
  always @(negedge clock) begin : monitor
    logic [63:0] e;
    if (o_done === 1'b1) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_done got hi=%h lo=%h exp no pulse", o_hi_32, o_lo_32);
      end else begin
        e = sb_q.pop_front();
        check("result", {o_hi_32, o_lo_32}, e);
      end
    end
  end

  task automatic drive_start(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
    i_func_6 = f;
    i_rs_32  = a;
    i_rt_32  = b;
    i_start  = 1'b1;
    @(posedge clock);
    #1;
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input string name, input int lat);
    int k = 0;
    while (o_done !== 1'b1 && k < 200) begin
      @(posedge clock);
      #1;
      k++;
    end
    check({name, "_lat"}, 64'(k), 64'(lat));
  endtask

  task automatic run_op(input string name, input logic [5:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    sb_q.push_back(exp);
    drive_start(f, a, b);
    wait_done(name, exp_lat(f, a, b));
  endtask

  initial begin
    int n;
    int bad;
    logic [5:0]  f;
    logic [31:0] a;
    logic [31:0] b;

    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    i_start  = 1'b0;
    i_func_6 = '0;
    i_rs_32  = '0;
    i_rt_32  = '0;
    i_rd_hi  = 1'b0;
    i_rd_lo  = 1'b0;
    i_wr_hi  = 1'b0;
    i_wr_lo  = 1'b0;

    vecs[0]  = '{FUNC_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
    vecs[1]  = '{FUNC_MULT,  32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
    vecs[2]  = '{FUNC_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3]  = '{FUNC_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
    vecs[4]  = '{FUNC_DIVU,  32'h0000000A, 32'h00000000, 32'h0000000A, 32'hFFFFFFFF};
    vecs[5]  = '{FUNC_DIV,   32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFB, 32'hFFFFFFFF};
    vecs[6]  = '{FUNC_MULT,  32'h00000000, 32'h00012345, 32'h00000000, 32'h00000000};
    vecs[7]  = '{FUNC_MULTU, 32'h12345678, 32'h00000000, 32'h00000000, 32'h00000000};
    vecs[8]  = '{FUNC_DIVU,  32'h00000064, 32'h00000007, 32'h00000002, 32'h0000000E};
    vecs[9]  = '{FUNC_DIV,   32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD};
    vecs[10] = '{FUNC_MULT,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
    vecs[11] = '{FUNC_MULTU, 32'h00010000, 32'h00010000, 32'h00000001, 32'h00000000};
    vecs[12] = '{FUNC_DIVU,  32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'hFFFFFFFF};
    vecs[13] = '{FUNC_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;

    // Reset state
    check("rst_hi", 64'(o_hi_32), 64'h0);
    check("rst_lo", 64'(o_lo_32), 64'h0);
    check("rst_busy", 64'(o_busy), 64'h0);
    check("rst_done", 64'(o_done), 64'h0);
    i_rd_hi = 1'b1;
    #1;
    check("idle_no_stall", 64'(o_stall), 64'h0);
    i_rd_hi = 1'b0;

    // MTLO / MTHI in IDLE
    i_wr_lo = 1'b1;
    i_rs_32 = 32'h00001234;
    @(posedge clock);
    #1;
    i_wr_lo = 1'b0;
    check("mtlo", 64'(o_lo_32), 64'h1234);
    i_wr_hi = 1'b1;
    i_rs_32 = 32'h0000CAFE;
    @(posedge clock);
    #1;
    i_wr_hi = 1'b0;
    check("mthi", 64'(o_hi_32), 64'hCAFE);

    // Non-muldiv func is ignored
    drive_start(6'h20, 32'h1, 32'h2);
    check("bad_func_ignored", 64'(o_busy), 64'h0);

    // Directed table (each op starts from DONE of the previous one)
    for (int i = 0; i < 14; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].func, vecs[i].rs, vecs[i].rt,
             {vecs[i].hi, vecs[i].lo});
    end

    // Explicit back-to-back acceptance from DONE
    sb_q.push_back(64'h0000_0000_0000_002A);
    drive_start(FUNC_MULTU, 32'h7, 32'h6);
    check("b2b_busy", 64'(o_busy), 64'h1);
    wait_done("b2b", FULL_LAT);

    // Random ops against the model
    for (int i = 0; i < 6; i++) begin
      f = FUNC_MULT + 6'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 2) ? 32'h0 : $urandom;
      if (i % 2 == 1) b = b >> 28;
      run_op("rand", f, a, b, model(f, a, b));
    end

    // MTHI in DONE, then MFHI held across a whole op with a stray start
    i_wr_hi = 1'b1;
    i_rs_32 = 32'h00000055;
    @(posedge clock);
    #1;
    i_wr_hi = 1'b0;
    check("mthi_done", 64'(o_hi_32), 64'h55);
    sb_q.push_back({32'h00000001, 32'hFFFFFFFE});
    drive_start(FUNC_MULTU, 32'hFFFFFFFF, 32'h2);
    i_rd_hi = 1'b1;
    n   = 0;
    bad = 0;
    while (o_done !== 1'b1 && n < 200) begin
      if (o_stall !== 1'b1) bad++;
      if (n == 5) begin
        i_start  = 1'b1;
        i_func_6 = FUNC_DIVU;
        i_rt_32  = 32'h0;
      end
      if (n == 6) i_start = 1'b0;
      @(posedge clock);
      #1;
      n++;
    end
    check("stall_lat", 64'(n), 64'(FULL_LAT));
    check("stall_held", 64'(bad), 64'h0);
    check("stall_release", 64'(o_stall), 64'h0);
    check("mfhi_new_hi", 64'(o_hi_32), 64'h1);
    i_rd_hi = 1'b0;
    @(posedge clock);
    #1;
    check("busy_start_ignored", 64'({o_busy, o_done}), 64'h0);

    // Reset in the middle of RUN aborts with no done pulse
    drive_start(FUNC_MULTU, 32'h00001234, 32'h00005678);
    repeat (10) @(posedge clock);
    #1;
    check("run_busy", 64'(o_busy), 64'h1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    reset = 1'b0;
    check("abort_busy", 64'(o_busy), 64'h0);
    check("abort_hilo", {o_hi_32, o_lo_32}, 64'h0);
    n = 0;
    for (int c = 0; c < 40; c++) begin
      if (o_done === 1'b1) n++;
      @(posedge clock);
      #1;
    end
    check("abort_no_done", 64'(n), 64'h0);

    check("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
